wired_cdb_arbiter: RTL and testbench
====================================

WIRED_CDB_ARBITER -- requirements
Module: wired_cdb_arbiter

Interface
REQ-001 SHALL have parameter SRC_CNT, default 4, number of result sources; index order is 0=ALU0, 1=ALU1, 2=LSU, 3=MDU.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied cycles after which a source is promoted.
REQ-003 SHALL have port clk  input  1  clock; the only clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush_i  input  1  backend pipeline flush.
REQ-006 SHALL have port src_cdb_i  input  SRC_CNT x pipeline_cdb_t  source results; the .valid field of each entry is the request.
REQ-007 SHALL have port src_ready_o  output  SRC_CNT  per-source accept, combinational; a source is consumed when src_cdb_i[i].valid & src_ready_o[i].
REQ-008 SHALL have port cdb_o  output  2 x pipeline_cdb_t  registered CDB lanes; lane b carries only results with wid[0]==b, one per ROB bank.
REQ-009 SHALL have port starve_cnt_o  output  32  saturating count of promoted grants, for performance monitoring.

Function
REQ-010 SHALL route each valid source to lane src_cdb_i[i].wid[0]; each source targets exactly one lane per cycle.
REQ-011 SHALL grant at most one source per lane per cycle; both lanes SHALL be granted in the same cycle when both have requesters.
REQ-012 SHALL keep a per-source wait counter of width clog2(STARVE_LIMIT+1).
REQ-013 The wait counter SHALL increment when the source is valid and not granted.
REQ-014 The wait counter SHALL saturate at STARVE_LIMIT.
REQ-015 The wait counter SHALL clear to 0 when the source is granted or is not valid.
REQ-016 Per lane: if any requester has a counter equal to STARVE_LIMIT, the lowest-index such requester SHALL win; otherwise the lowest-index requester SHALL win (ALU0 > ALU1 > LSU > MDU).
REQ-017 src_ready_o[i] SHALL be 1 only for the granted source of its lane, and only when flush_i and rst are both 0; it SHALL NOT depend on cdb_o.
REQ-018 When the granted source on a lane wins via promotion, starve_cnt_o SHALL increment once per such lane-grant; two promoted lane-grants in the same cycle SHALL add 2; it SHALL saturate at 0xFFFFFFFF.
REQ-019 cdb_o[b] SHALL equal the granted payload registered one cycle after acceptance, with .valid=1; latency is exactly 1 cycle.
REQ-020 If lane b has no grant, cdb_o[b].valid SHALL be 0 on the next cycle; payload fields are don't-care when valid is 0.
REQ-021 cdb_o has no backpressure; the downstream ROB and IQ snoopers SHALL consume every valid lane every cycle.
REQ-022 If flush_i=1: src_ready_o SHALL be all 0; cdb_o[*].valid SHALL be 0 on the next cycle; all wait counters SHALL clear.
REQ-023 flush_i SHALL NOT clear starve_cnt_o.
REQ-024 A source whose .valid is 0 SHALL NOT affect arbitration, counters, or the lane of any other source.
REQ-025 A source that is valid but not granted SHALL hold its payload; the arbiter SHALL NOT buffer it.
REQ-026 Total RTL SHALL contain no combinational path from cdb_o to src_ready_o.

Reset
REQ-027 On rst=1 at a clock edge: cdb_o[*].valid SHALL be 0; all wait counters SHALL be 0; starve_cnt_o SHALL be 0.
REQ-028 During rst=1, src_ready_o SHALL be all 0.
REQ-029 Reset asserted mid-operation SHALL discard any result registered but not yet presented, with no partial lane update.
REQ-030 The first grant after reset deassertion SHALL occur in the first cycle with rst=0.

Verification
REQ-031 Bank split: ALU0 wid=6 and LSU wid=9 valid in cycle N -> both ready in N; cycle N+1 cdb_o[0].wid=6 and cdb_o[1].wid=9, both valid.
REQ-032 Conflict: ALU0 wid=4 and MDU wid=2 (both bank 0) held valid -> ALU0 granted in N; MDU granted in N+1; cdb_o[0] carries wid 4 at N+1, then wid 2 at N+2.
REQ-033 Starvation: ALU0 and ALU1 stream bank-0 results every cycle, LSU wid=8 held valid from cycle 0 -> LSU counter reaches 4 at cycle 4; LSU granted in cycle 4; starve_cnt_o=1 at cycle 5.
REQ-034 Flush: 3 sources valid and flush_i=1 in cycle N -> src_ready_o=0 in N; cdb_o valid=0 at N+1; counters 0.
REQ-035 Reset mid-stream: rst=1 while both lanes are valid -> next cycle cdb_o valid=0 and starve_cnt_o=0.
REQ-036 Idle: no source valid for 10 cycles -> cdb_o valid stays 0; counters stay 0; starve_cnt_o is unchanged.

Source files
------------

// File: rtl/wired_cdb_arbiter.sv
// Wired common-data-bus arbiter.
// Collects results from SRC_CNT execution sources and drives two CDB lanes,
// one per ROB bank (lane b carries results whose wid[0] == b). Each lane
// grants one source per cycle. The lowest index wins, except that a source
// denied STARVE_LIMIT cycles in a row is promoted ahead of the others. The
// granted payload is registered and presented on cdb_o one cycle later.
//
// Handshake: a source offers a result by raising src_cdb_i[i].valid and holds
// the payload stable until it sees src_ready_o[i]. The transfer happens in the
// cycle where valid & ready are both 1. src_ready_o is combinational from
// src_cdb_i, flush_i and rst only. cdb_o has no backpressure: every valid lane
// is consumed in the cycle it is presented.

package wired_cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  wid;
        logic [31:0] data;
    } pipeline_cdb_t;

    localparam int CDB_W = $bits(pipeline_cdb_t);
endpackage

module wired_cdb_arbiter
    import wired_cdb_pkg::*;
#(
    parameter int SRC_CNT      = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [SRC_CNT*CDB_W-1:0]   src_cdb_i,
    output logic [SRC_CNT-1:0]         src_ready_o,
    output logic [2*CDB_W-1:0]         cdb_o,
    output logic [31:0]                starve_cnt_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int IW = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    pipeline_cdb_t       src      [SRC_CNT];
    logic [CW-1:0]       wait_cnt [SRC_CNT];
    pipeline_cdb_t       cdb_q    [2];

    logic [SRC_CNT-1:0]  grant;
    logic [IW-1:0]       grant_idx  [2];
    logic [1:0]          lane_hit;
    logic [1:0]          lane_promo;

    logic [IW-1:0]       norm_idx   [2];
    logic [IW-1:0]       promo_idx  [2];
    logic [1:0]          norm_hit;
    logic [1:0]          promo_hit;

    logic [1:0]          promo_add;
    logic [32:0]         starve_sum;

    // Unpack the flat source bus into per-source result records.
    always_comb begin
        for (int i = 0; i < SRC_CNT; i++) begin
            src[i] = src_cdb_i[i*CDB_W +: CDB_W];
        end
    end

    // Per-lane pick: promoted requesters first, else the lowest index.
    // Scanning from the top down lets the lowest index overwrite the others.
    always_comb begin
        grant      = '0;
        lane_hit   = '0;
        lane_promo = '0;
        norm_hit   = '0;
        promo_hit  = '0;
        for (int b = 0; b < 2; b++) begin
            norm_idx[b]  = '0;
            promo_idx[b] = '0;
            grant_idx[b] = '0;
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = SRC_CNT - 1; i >= 0; i--) begin
                if (src[i].valid && (src[i].wid[0] == b[0])) begin
                    norm_hit[b] = 1'b1;
                    norm_idx[b] = IW'(i);
                    if (wait_cnt[i] == LIMIT) begin
                        promo_hit[b] = 1'b1;
                        promo_idx[b] = IW'(i);
                    end
                end
            end
            lane_hit[b]   = norm_hit[b];
            lane_promo[b] = promo_hit[b];
            grant_idx[b]  = promo_hit[b] ? promo_idx[b] : norm_idx[b];
            if (norm_hit[b]) begin
                grant[grant_idx[b]] = 1'b1;
            end
        end
    end

    // Ready is suppressed during flush and reset; it never looks at cdb_o.
    assign src_ready_o = grant & {SRC_CNT{~flush_i & ~rst}};

    // Promoted lane-grants that actually transfer this cycle (0, 1 or 2).
    assign promo_add  = {1'b0, lane_promo[0] & ~flush_i} + {1'b0, lane_promo[1] & ~flush_i};
    assign starve_sum = {1'b0, starve_cnt_o} + 33'(promo_add);

    // Per-source wait counters: count denied cycles, saturate, clear on grant/idle/flush.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRC_CNT; i++) begin
            if (rst || flush_i) begin
                wait_cnt[i] <= '0;
            end else if (src[i].valid && !grant[i]) begin
                if (wait_cnt[i] != LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end else begin
                wait_cnt[i] <= '0;
            end
        end
    end

    // Lane output registers: capture the granted payload, valid only on a real transfer.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                cdb_q[b] <= '0;
            end else begin
                cdb_q[b]       <= src[grant_idx[b]];
                cdb_q[b].valid <= lane_hit[b] & ~flush_i;
            end
        end
    end

    // Saturating performance counter of promoted lane-grants; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_o <= '0;
        end else if (starve_sum[32]) begin
            starve_cnt_o <= 32'hFFFF_FFFF;
        end else begin
            starve_cnt_o <= starve_sum[31:0];
        end
    end

    assign cdb_o = {cdb_q[1], cdb_q[0]};

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Directed bench for wired_cdb_arbiter: bank split, conflicts, starvation
// promotion, dual promotion, flush, idle and mid-stream reset.
module tb_wired_cdb_arbiter;
    import wired_cdb_pkg::*;

    localparam int N = 4;
    localparam int W = CDB_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    pipeline_cdb_t     src [N];
    logic [N*W-1:0]    src_flat;
    logic [N-1:0]      ready;
    logic [2*W-1:0]    cdb_flat;
    logic [31:0]       starve;
    pipeline_cdb_t     lane0;
    pipeline_cdb_t     lane1;

    int checks = 0;
    int passes = 0;

    wired_cdb_arbiter #(.SRC_CNT(N), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .src_cdb_i    (src_flat),
        .src_ready_o  (ready),
        .cdb_o        (cdb_flat),
        .starve_cnt_o (starve)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) src_flat[i*W +: W] = src[i];
    end
    assign lane0 = cdb_flat[W-1:0];
    assign lane1 = cdb_flat[2*W-1:W];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src[i] = '0;
    endtask

    task automatic put(input int i, input logic [5:0] wid);
        src[i].valid = 1'b1;
        src[i].wid   = wid;
        src[i].data  = 32'hA000_0000 | 32'(wid) | 32'(i << 8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_src();
        put(0, 6'd6);
        put(3, 6'd1);
        #1;
        checks++;
        if (ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", ready); else passes++;
        tick();
        checks++;
        if ({lane1.valid, lane0.valid} !== 2'b00) $display("FAIL reset_valid got %b want 00", {lane1.valid, lane0.valid}); else passes++;
        checks++;
        if (starve !== 32'd0) $display("FAIL reset_starve got %0d want 0", starve); else passes++;
        clear_src();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bank_split();
        clear_src();
        put(0, 6'd6);
        put(2, 6'd9);
        #1;
        checks++;
        if (ready !== 4'b0101) $display("FAIL split_ready got %b want 0101", ready); else passes++;
        tick();
        checks++;
        if (lane0.valid !== 1'b1 || lane0.wid !== 6'd6 || lane0.data !== 32'hA000_0006)
            $display("FAIL split_lane0 got v=%b wid=%0d data=%h want v=1 wid=6 data=a0000006", lane0.valid, lane0.wid, lane0.data);
        else passes++;
        checks++;
        if (lane1.valid !== 1'b1 || lane1.wid !== 6'd9 || lane1.data !== 32'hA000_0209)
            $display("FAIL split_lane1 got v=%b wid=%0d data=%h want v=1 wid=9 data=a0000209", lane1.valid, lane1.wid, lane1.data);
        else passes++;
        clear_src();
        tick();
        checks++;
        if ({lane1.valid, lane0.valid} !== 2'b00) $display("FAIL split_drain got %b want 00", {lane1.valid, lane0.valid}); else passes++;
    endtask

    task automatic test_conflict();
        clear_src();
        put(0, 6'd4);
        put(3, 6'd2);
        #1;
        checks++;
        if (ready !== 4'b0001) $display("FAIL conflict_ready0 got %b want 0001", ready); else passes++;
        tick();
        checks++;
        if (lane0.valid !== 1'b1 || lane0.wid !== 6'd4) $display("FAIL conflict_lane0_first got v=%b wid=%0d want v=1 wid=4", lane0.valid, lane0.wid); else passes++;
        src[0].valid = 1'b0;
        #1;
        checks++;
        if (ready !== 4'b1000) $display("FAIL conflict_ready1 got %b want 1000", ready); else passes++;
        tick();
        checks++;
        if (lane0.valid !== 1'b1 || lane0.wid !== 6'd2 || lane1.valid !== 1'b0)
            $display("FAIL conflict_lane0_second got v=%b wid=%0d l1v=%b want v=1 wid=2 l1v=0", lane0.valid, lane0.wid, lane1.valid);
        else passes++;
        clear_src();
        tick();
        checks++;
        if (lane0.valid !== 1'b0) $display("FAIL conflict_drain got %b want 0", lane0.valid); else passes++;
    endtask

    // ALU0 and ALU1 alternate bank-0 results each cycle; LSU (wid 8) waits.
    task automatic test_starvation();
        logic [3:0] exp_ready;
        for (int k = 0; k < 5; k++) begin
            clear_src();
            put(2, 6'd8);
            put(k % 2, 6'(2 * k + 10));
            #1;
            exp_ready = (k < 4) ? 4'(1 << (k % 2)) : 4'b0100;
            checks++;
            if (ready !== exp_ready) $display("FAIL starve_ready_c%0d got %b want %b", k, ready, exp_ready); else passes++;
            tick();
        end
        checks++;
        if (starve !== 32'd1) $display("FAIL starve_count got %0d want 1", starve); else passes++;
        checks++;
        if (lane0.valid !== 1'b1 || lane0.wid !== 6'd8) $display("FAIL starve_lane0 got v=%b wid=%0d want v=1 wid=8", lane0.valid, lane0.wid); else passes++;
        clear_src();
        tick();
    endtask

    // Both lanes starve a source at once: promoted grants add 2.
    task automatic test_dual_promo();
        clear_src();
        put(0, 6'd2);
        put(1, 6'd3);
        put(2, 6'd12);
        put(3, 6'd15);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (ready !== 4'b0011) $display("FAIL dual_ready_c%0d got %b want 0011", k, ready); else passes++;
            tick();
        end
        checks++;
        if (ready !== 4'b1100) $display("FAIL dual_ready_promo got %b want 1100", ready); else passes++;
        tick();
        checks++;
        if (starve !== 32'd3) $display("FAIL dual_count got %0d want 3", starve); else passes++;
        checks++;
        if (lane0.wid !== 6'd12 || lane1.wid !== 6'd15 || {lane1.valid, lane0.valid} !== 2'b11)
            $display("FAIL dual_lanes got wid0=%0d wid1=%0d v=%b want 12 15 11", lane0.wid, lane1.wid, {lane1.valid, lane0.valid});
        else passes++;
        clear_src();
        tick();
    endtask

    // LSU builds up 3 denials, flush must wipe them so it is not promoted afterwards.
    task automatic test_flush();
        clear_src();
        put(0, 6'd4);
        put(2, 6'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ready !== 4'b0001) $display("FAIL flush_pre_ready_c%0d got %b want 0001", k, ready); else passes++;
            tick();
        end
        put(1, 6'd1);
        flush = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0000) $display("FAIL flush_ready got %b want 0000", ready); else passes++;
        tick();
        flush = 1'b0;
        checks++;
        if ({lane1.valid, lane0.valid} !== 2'b00) $display("FAIL flush_valid got %b want 00", {lane1.valid, lane0.valid}); else passes++;
        checks++;
        if (starve !== 32'd3) $display("FAIL flush_starve got %0d want 3", starve); else passes++;
        #1;
        checks++;
        if (ready !== 4'b0011) $display("FAIL flush_counter_clear got %b want 0011", ready); else passes++;
        tick();
        clear_src();
        tick();
    endtask

    task automatic test_idle();
        clear_src();
        tick();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({lane1.valid, lane0.valid} !== 2'b00 || starve !== 32'd3)
                $display("FAIL idle_c%0d got v=%b starve=%0d want v=00 starve=3", k, {lane1.valid, lane0.valid}, starve);
            else passes++;
            tick();
        end
        put(0, 6'd0);
        put(2, 6'd2);
        #1;
        checks++;
        if (ready !== 4'b0001) $display("FAIL idle_counters got %b want 0001", ready); else passes++;
        tick();
        clear_src();
        tick();
    endtask

    task automatic test_reset_mid();
        clear_src();
        put(0, 6'd2);
        put(1, 6'd3);
        #1;
        checks++;
        if (ready !== 4'b0011) $display("FAIL rmid_ready got %b want 0011", ready); else passes++;
        tick();
        checks++;
        if ({lane1.valid, lane0.valid} !== 2'b11) $display("FAIL rmid_pre_valid got %b want 11", {lane1.valid, lane0.valid}); else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0000) $display("FAIL rmid_ready_rst got %b want 0000", ready); else passes++;
        tick();
        checks++;
        if ({lane1.valid, lane0.valid} !== 2'b00) $display("FAIL rmid_valid got %b want 00", {lane1.valid, lane0.valid}); else passes++;
        checks++;
        if (starve !== 32'd0) $display("FAIL rmid_starve got %0d want 0", starve); else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 4'b0011) $display("FAIL rmid_first_grant got %b want 0011", ready); else passes++;
        tick();
        checks++;
        if (lane0.wid !== 6'd2 || lane1.wid !== 6'd3 || {lane1.valid, lane0.valid} !== 2'b11)
            $display("FAIL rmid_post got wid0=%0d wid1=%0d v=%b want 2 3 11", lane0.wid, lane1.wid, {lane1.valid, lane0.valid});
        else passes++;
        clear_src();
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clear_src();
        tick();
        tick();
        test_reset();
        test_bank_split();
        test_conflict();
        test_starvation();
        test_dual_promo();
        test_flush();
        test_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
